// File: rtl/kinase_seq_pkg.sv
// Shared types, valve bit positions and command decoding for the kinase valve sequencer.
// The 22-bit valve vector is ordered c1..c13, s1..s4, p1..p5 from bit 0 upward.
package kinase_seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_CIRC  = 3'd1,
    OP_WASH  = 3'd2,
    OP_ELUTE = 3'd3,
    OP_DRAIN = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_PUMP   = 3'd2,
    ST_CLOSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PK_NONE = 2'd0,
    PK_TRI  = 2'd1,
    PK_DUAL = 2'd2
  } pump_kind_e;

  localparam int V1  = 0;
  localparam int V2  = 1;
  localparam int V3  = 2;
  localparam int V4  = 3;
  localparam int V5  = 4;
  localparam int V6  = 5;
  localparam int V7  = 6;
  localparam int V8  = 7;
  localparam int V9  = 8;
  localparam int V10 = 9;
  localparam int V11 = 10;
  localparam int V12 = 11;
  localparam int V13 = 12;
  localparam int VS1 = 13;
  localparam int VS2 = 14;
  localparam int VS3 = 15;
  localparam int VS4 = 16;
  localparam int VP1 = 17;
  localparam int VP2 = 18;
  localparam int VP3 = 19;
  localparam int VP4 = 20;
  localparam int VP5 = 21;

  // Valves held open for the whole command; pump valves are driven by the phaser.
  function automatic logic [21:0] route_mask(input op_e op, input logic [1:0] sel);
    logic [21:0] m;
    m = '0;
    case (op)
      OP_LOAD: begin
        case (sel)
          2'd0:    m[V1] = 1'b1;
          2'd1:    m[V2] = 1'b1;
          2'd2:    m[V3] = 1'b1;
          default: m[V1] = 1'b0;
        endcase
        m[V4] = 1'b1;
        m[V5] = 1'b1;
      end
      OP_CIRC: begin
        m[V7]  = 1'b1;
        m[V9]  = 1'b1;
        m[V10] = 1'b1;
        m[VS3] = 1'b1;
      end
      OP_WASH: begin
        m[V4]  = 1'b1;
        m[V6]  = 1'b1;
        m[VS1] = 1'b1;
      end
      OP_ELUTE: begin
        m[VS4] = 1'b1;
        if (sel == 2'd0) m[V12] = 1'b1;
        else             m[V13] = 1'b1;
      end
      OP_DRAIN: m[V8] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  function automatic logic cmd_legal(input op_e op, input logic [1:0] sel);
    case (op)
      OP_LOAD:                    return sel != 2'd3;
      OP_CIRC, OP_WASH, OP_DRAIN: return 1'b1;
      OP_ELUTE:                   return sel <= 2'd1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic pump_kind_e pump_kind(input op_e op);
    case (op)
      OP_LOAD, OP_CIRC: return PK_TRI;
      OP_WASH:          return PK_DUAL;
      default:          return PK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/kinase_valve_sequencer_phaser.sv
// Peristaltic phase timer: steps through 1, 2 or 3 pump phases of PHASE_CYCLES clocks each.
// open_next is the pump-valve open pattern that will hold after the current edge.
module peristaltic_phaser
  import kinase_seq_pkg::*;
#(
  parameter int PHASE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       run,
  input  pump_kind_e kind,
  input  logic       rev,
  output logic [4:0] open_next,
  output logic       cycle_done
);

  localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);

  logic [TW-1:0] timer_reg, timer_next;
  logic [1:0]    phase_reg, phase_next, phase_last, slot;
  logic          phase_end;

  always_comb begin
    case (kind)
      PK_TRI:  phase_last = 2'd2;
      PK_DUAL: phase_last = 2'd1;
      default: phase_last = 2'd0;
    endcase
  end

  assign phase_end  = run && (timer_reg == T_LAST);
  assign cycle_done = phase_end && (phase_reg == phase_last);

  always_comb begin
    timer_next = timer_reg;
    phase_next = phase_reg;
    if (start) begin
      timer_next = '0;
      phase_next = '0;
    end else if (run) begin
      if (timer_reg == T_LAST) begin
        timer_next = '0;
        phase_next = (phase_reg == phase_last) ? 2'd0 : phase_reg + 2'd1;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end
  end

  // Reverse direction walks the same phase sequence from the far end of the pump.
  assign slot = rev ? (phase_last - phase_next) : phase_next;

  always_comb begin
    case (kind)
      PK_TRI:  open_next = 5'b00001 << slot;
      PK_DUAL: open_next = 5'b01000 << slot;
      default: open_next = 5'b00000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
      phase_reg <= '0;
    end else begin
      timer_reg <= timer_next;
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Command-driven valve sequencer for the kinase_activity chip (1 = pressurised = closed).
// Define KINASE_STROKE_CNT_EN to add the saturating stroke_cnt output.
module kinase_valve_sequencer
  import kinase_seq_pkg::*;
#(
  parameter int PHASE_CYCLES  = 1000,
  parameter int SETTLE_CYCLES = 500,
  parameter int LEN_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_sel,
  input  logic             cmd_rev,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic [12:0]      c_ctl,
  output logic [3:0]       s_ctl,
  output logic [4:0]       p_ctl,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef KINASE_STROKE_CNT_EN
  ,
  output logic [31:0]      stroke_cnt
`endif
);

  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);

  state_e           state_reg;
  pump_kind_e       kind_reg;
  logic             rev_reg;
  logic [LEN_W-1:0] len_reg, cyc_reg;
  logic [STW-1:0]   tmr_reg;

  op_e        op_in;
  logic [21:0] open_mask;
  logic       tmr_last, pump_start, pump_run, cycle_done, to_close;
  logic [4:0] p_open_next;

  assign op_in      = op_e'(cmd_op);
  assign open_mask  = route_mask(op_in, cmd_sel);
  assign tmr_last   = (tmr_reg == SETTLE_LAST);
  assign pump_start = (state_reg == ST_SETTLE) && tmr_last && !abort && (len_reg != '0);
  assign pump_run   = (state_reg == ST_PUMP);

  // Every path into CLOSE: abort, zero-length command, or the last pump cycle finishing.
  assign to_close = ((state_reg == ST_SETTLE) && (abort || (tmr_last && (len_reg == '0)))) ||
                    ((state_reg == ST_PUMP) &&
                     (abort || (cycle_done && (cyc_reg == len_reg - 1'b1))));

  peristaltic_phaser #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phaser (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (pump_start),
    .run       (pump_run),
    .kind      (kind_reg),
    .rev       (rev_reg),
    .open_next (p_open_next),
    .cycle_done(cycle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      kind_reg  <= PK_NONE;
      rev_reg   <= 1'b0;
      len_reg   <= '0;
      cyc_reg   <= '0;
      tmr_reg   <= '0;
      c_ctl     <= '1;
      s_ctl     <= '1;
      p_ctl     <= '1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (to_close) begin
        state_reg <= ST_CLOSE;
        tmr_reg   <= '0;
        c_ctl     <= '1;
        s_ctl     <= '1;
        p_ctl     <= '1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
              if (cmd_legal(op_in, cmd_sel)) begin
                state_reg <= ST_SETTLE;
                busy      <= 1'b1;
                kind_reg  <= pump_kind(op_in);
                rev_reg   <= cmd_rev;
                len_reg   <= cmd_len;
                tmr_reg   <= '0;
                c_ctl     <= ~open_mask[V13:V1];
                s_ctl     <= ~open_mask[VS4:VS1];
                p_ctl     <= ~open_mask[VP5:VP1];
              end else begin
                state_reg <= ST_DONE;
                done      <= 1'b1;
                err       <= 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (tmr_last) begin
              state_reg <= ST_PUMP;
              cyc_reg   <= '0;
              p_ctl     <= ~p_open_next;
            end else begin
              tmr_reg <= tmr_reg + 1'b1;
            end
          end
          ST_PUMP: begin
            p_ctl <= ~p_open_next;
            if (cycle_done) cyc_reg <= cyc_reg + 1'b1;
          end
          ST_CLOSE: begin
            if (tmr_last) begin
              state_reg <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              tmr_reg <= tmr_reg + 1'b1;
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef KINASE_STROKE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stroke_cnt <= '0;
    end else if (pump_run && cycle_done && (kind_reg != PK_NONE) &&
                 (stroke_cnt != 32'hFFFF_FFFF)) begin
      stroke_cnt <= stroke_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/kinase_valve_sequencer.md
Name: kinase_valve_sequencer

Overview:
- Digital controller that drives the 22 pneumatic control lines (c1..c13, s1..s4, p1..p5) of the kinase_activity microfluidic chip.
- Accepts protocol commands over a valid/ready handshake and translates each command into a timed valve pattern.
- Runs peristaltic pumping on the vp1-vp3 triple or the vp4/vp5 pair.
- Sits between the host protocol engine and the solenoid driver board.

Parameters:
- PHASE_CYCLES, 1000: clock cycles per pump phase; must be >= 1.
- SETTLE_CYCLES, 500: clock cycles of dwell after a valve route opens and after it closes; must be >= 1.
- LEN_W, 16: width of the pump-cycle count field.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  operation code: 0 LOAD, 1 CIRC, 2 WASH, 3 ELUTE, 4 DRAIN.
- cmd_sel  in  2  LOAD: input select 0/1/2 → v1/v2/v3. ELUTE: output select 0 → v12, 1 → v13.
- cmd_rev  in  1  reverse the pump direction.
- cmd_len  in  LEN_W  number of pump cycles (or dwell phases for unpumped ops).
- abort  in  1  terminate the current command safely.
- c_ctl  out  13  air lines for c1..c13; bit0 = c1.
- s_ctl  out  4  air lines for s1..s4.
- p_ctl  out  5  air lines for p1..p5.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; set for an illegal op or sel.

Behaviour:
- Air-line encoding: 1 = pressurised = valve closed.
- Reset (asynchronous, also mid-command):
  - c_ctl = 13'h1FFF, s_ctl = 4'hF, p_ctl = 5'h1F (all valves closed).
  - cmd_ready = 1, busy = 0, done = 0, err = 0.
  - FSM returns to IDLE.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready = (state == IDLE). Command fields are latched on acceptance.
- Route mask (valves held open during the command):
  - LOAD: v[sel], v4, v5; pumps p1-p3.
  - CIRC: v7, v9, v10, s3; pumps p1-p3.
  - WASH: v4, v6, s1; pumps p4/p5.
  - ELUTE: s4, v12 or v13; no pump.
  - DRAIN: v8; no pump.
- Illegal command: op > 4, or LOAD with sel == 3, or ELUTE with sel > 1.
  - No valve changes.
  - IDLE → DONE with err = 1 on the next cycle.
- FSM states: IDLE → SETTLE → PUMP → CLOSE → DONE → IDLE.
- SETTLE:
  - Route mask applied, all pump valves closed.
  - Lasts SETTLE_CYCLES cycles.
- PUMP, 3-phase pumps (open valve per phase):
  - Forward: p1 → p2 → p3.
  - Reverse: p3 → p2 → p1.
  - One pump cycle = 3 phases.
- PUMP, 2-phase pumps (open valve per phase):
  - Forward: p4 → p5.
  - Reverse: p5 → p4.
  - One pump cycle = 2 phases.
- PUMP, unpumped ops: all p closed; each "cycle" is one phase of dwell.
- PUMP timing:
  - Each phase lasts exactly PHASE_CYCLES cycles.
  - The state lasts cmd_len pump cycles.
  - cmd_len == 0 skips PUMP: SETTLE goes directly to CLOSE.
- CLOSE:
  - All valves closed.
  - Lasts SETTLE_CYCLES cycles, then DONE.
- DONE: done = 1 and busy = 0 for one cycle, err = 0; then IDLE.
- busy = 1 in SETTLE, PUMP and CLOSE.
- Abort:
  - abort = 1 in SETTLE or PUMP forces CLOSE on the next edge; the CLOSE timer restarts.
  - abort is ignored in CLOSE, DONE and IDLE.
  - Abort and cmd acceptance in the same IDLE cycle: the command is accepted and abort is ignored.
- Output registration: all outputs are registered. Valve outputs change on the same edge as the state or phase transition. Unused valves stay closed at all times.
- Counters:
  - The phase counter counts 0..PHASE_CYCLES-1 and wraps.
  - The pump-cycle counter is LEN_W bits wide and never wraps, because it is compared against the latched cmd_len.

Optional Feature:
- Macro: KINASE_STROKE_CNT_EN.
- Defined: adds output stroke_cnt[31:0].
  - Increments on each completed pump cycle of a pumped op.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package kinase_seq_pkg:
  - op enum.
  - state enum.
  - Valve bit-index constants (V1..V13, VS1..VS4, VP1..VP5).
  - Route-mask function mapping op/sel to 22-bit open masks.
  - Pump-kind enum (NONE, TRI, DUAL).
- Sub-module peristaltic_phaser:
  - Phase timer and phase index for 2- or 3-phase pumps.
  - Direction input.
  - cycle_done pulse output.

Test Plan (PHASE_CYCLES=4, SETTLE_CYCLES=3):
- Reset check: assert rst_n=0 mid-PUMP → outputs immediately read 1FFF/F/1F, cmd_ready=1, busy=0.
- LOAD sel=1 len=2 fwd:
  - c2, c4, c5 low for 3+24 cycles.
  - p_ctl cycles 11110, 11101, 11011 (4 cycles each), twice.
  - Then 3 cycles all closed; done pulse at cycle 31 after acceptance.
- WASH len=1 rev: p_ctl shows 01111 then 10111 (4 cycles each); c4, c6, s1 open; p1-p3 stay 1.
- Abort on cycle 6 of CIRC len=5: next edge all valves closed; done after 3 more cycles; err=0.
- ELUTE sel=2 → done and err high one cycle after acceptance; valve outputs never change.
- cmd_valid held during busy: cmd_ready=0, no second accept until after DONE. cmd_len=0 DRAIN: v8 open 3 cycles, closed 3 cycles, done.
